ps2_kbd_port: RTL

Z80 I/O-mapped keyboard port. It sits between the `ps2` event decoder and the CPU data-in mux. It converts PS/2 set-2 make events into ASCII, tracks the modifier keys, and buffers the characters in a FIFO. Software polls the port through a status/data register pair, in the style of the ACIA. It can optionally request an interrupt on `n_int`.

---
 rtl/ps2_kbd_port.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_port.sv
// PS/2 set-2 keyboard port: scancode events to ASCII, modifier tracking and a character FIFO
// read by the CPU through a status/data register pair.
module ps2_kbd_port #(
   parameter int unsigned c_fifo_abits = 3
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [10:0] ps2_key,
   input  logic        cs,
   input  logic        rs,
   input  logic        n_rd,
   input  logic        n_wr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        n_int
);

   localparam int unsigned Depth = 2 ** c_fifo_abits;
   localparam logic [c_fifo_abits-1:0] PtrOne = 1;
   localparam logic [c_fifo_abits:0] CntOne = 1;
   localparam logic [c_fifo_abits:0] CntFull = Depth[c_fifo_abits:0];

   logic [10:0] key_q;
   logic        tog_prev_q, primed_q;
   logic        shift_q, ctrl_q, caps_q, ie_q, ovr_q;
   logic        push_q;
   logic [7:0]  char_q;
   logic        rd_act_q, rs_rd_q, wr_act_q;
   logic [7:0]  mem [Depth];
   logic [c_fifo_abits-1:0] wr_ptr_q, rd_ptr_q;
   logic [c_fifo_abits:0]   count_q;

   logic       ev, rd_act, wr_act, wr_first, pop_req, pop, do_push, empty, full;
   logic       is_letter, valid;
   logic [7:0] lc, base, shf, ascii;
   logic [7:0] code;

   assign code     = key_q[7:0];
   assign ev       = primed_q & (key_q[10] ^ tog_prev_q);
   assign rd_act   = cs & ~n_rd;
   assign wr_act   = cs & ~n_wr;
   assign wr_first = wr_act & ~wr_act_q;
   assign pop_req  = rd_act_q & ~rd_act & rs_rd_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CntFull);
   assign pop      = pop_req & ~empty;
   assign do_push  = push_q & (~full | pop);
   assign n_int    = ~(ie_q & ~empty);

   // Scancode table: letters give lowercase, everything else gives {unshifted, shifted}.
   always_comb begin
      lc        = 8'h00;
      base      = 8'h00;
      shf       = 8'h00;
      is_letter = 1'b0;
      valid     = 1'b1;
      if (key_q[8]) begin
         if (code == 8'h5a) begin
            base = 8'h0d;
            shf  = 8'h0d;
         end else begin
            valid = 1'b0;
         end
      end else begin
         unique case (code)
            8'h1c: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;  8'h2b: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;  8'h3b: lc = 8'h6a;  8'h42: lc = 8'h6b;  8'h4b: lc = 8'h6c;
            8'h3a: lc = 8'h6d;  8'h31: lc = 8'h6e;  8'h44: lc = 8'h6f;  8'h4d: lc = 8'h70;
            8'h15: lc = 8'h71;  8'h2d: lc = 8'h72;  8'h1b: lc = 8'h73;  8'h2c: lc = 8'h74;
            8'h3c: lc = 8'h75;  8'h2a: lc = 8'h76;  8'h1d: lc = 8'h77;  8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;  8'h1a: lc = 8'h7a;
            8'h16: {base, shf} = 16'h3121;  8'h1e: {base, shf} = 16'h3240;
            8'h26: {base, shf} = 16'h3323;  8'h25: {base, shf} = 16'h3424;
            8'h2e: {base, shf} = 16'h3525;  8'h36: {base, shf} = 16'h365e;
            8'h3d: {base, shf} = 16'h3726;  8'h3e: {base, shf} = 16'h382a;
            8'h46: {base, shf} = 16'h3928;  8'h45: {base, shf} = 16'h3029;
            8'h0e: {base, shf} = 16'h607e;  8'h4e: {base, shf} = 16'h2d5f;
            8'h55: {base, shf} = 16'h3d2b;  8'h54: {base, shf} = 16'h5b7b;
            8'h5b: {base, shf} = 16'h5d7d;  8'h5d: {base, shf} = 16'h5c7c;
            8'h4c: {base, shf} = 16'h3b3a;  8'h52: {base, shf} = 16'h2722;
            8'h41: {base, shf} = 16'h2c3c;  8'h49: {base, shf} = 16'h2e3e;
            8'h4a: {base, shf} = 16'h2f3f;
            8'h29: {base, shf} = 16'h2020;  8'h5a: {base, shf} = 16'h0d0d;
            8'h66: {base, shf} = 16'h0808;  8'h76: {base, shf} = 16'h1b1b;
            8'h0d: {base, shf} = 16'h0909;
            default: valid = 1'b0;
         endcase
         is_letter = (lc != 8'h00);
      end
   end

   always_comb begin
      ascii = shift_q ? shf : base;
      if (is_letter) begin
         if (ctrl_q)                ascii = lc & 8'h1f;
         else if (shift_q ^ caps_q) ascii = lc & 8'hdf;
         else                       ascii = lc;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         key_q      <= '0;
         tog_prev_q <= 1'b0;
         primed_q   <= 1'b0;
         shift_q    <= 1'b0;
         ctrl_q     <= 1'b0;
         caps_q     <= 1'b0;
         push_q     <= 1'b0;
         char_q     <= '0;
      end else begin
         key_q      <= ps2_key;
         primed_q   <= 1'b1;
         // Until primed, track the live toggle so a stale reset value never looks like an event.
         tog_prev_q <= primed_q ? key_q[10] : ps2_key[10];
         push_q     <= ev & key_q[9] & valid;
         char_q     <= ascii;
         if (ev) begin
            if (!key_q[8] && (code == 8'h12 || code == 8'h59)) shift_q <= key_q[9];
            if (code == 8'h14) ctrl_q <= key_q[9];
            if (!key_q[8] && code == 8'h58 && key_q[9]) caps_q <= ~caps_q;
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
         ie_q     <= 1'b0;
         rd_act_q <= 1'b0;
         rs_rd_q  <= 1'b0;
         wr_act_q <= 1'b0;
      end else begin
         rd_act_q <= rd_act;
         wr_act_q <= wr_act;
         if (rd_act) rs_rd_q <= rs;
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
         if (do_push && !pop)      count_q <= count_q + CntOne;
         else if (!do_push && pop) count_q <= count_q - CntOne;
         if (wr_first && !rs) begin
            ie_q <= data_in[7];
            if (data_in[1]) ovr_q <= 1'b0;
         end
         if (push_q && full && !pop) ovr_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= char_q;
   end

   always_comb begin
      if (rs) data_out = empty ? 8'h00 : mem[rd_ptr_q];
      else    data_out = {ie_q, 2'b00, caps_q, ctrl_q, shift_q, ovr_q, ~empty};
   end

endmodule
